// File: rtl/queen_controller_if.sv
// Control/status bundle between the 8-queen sequencer and its backtracking datapath.
interface queen_controller_if;
   // datapath status
   logic cout;
   logic down_counter_zero;
   logic last_queen_counter_zero;
   logic last_cell;
   logic safe;
   // datapath control
   logic reset_counter;
   logic shift_right;
   logic count_up;
   logic count_down;
   logic load_counter;
   logic count;
   logic enable_output;

   // Sequencer side: reads status, drives controls.
   modport master (
      input  cout, down_counter_zero, last_queen_counter_zero, last_cell, safe,
      output reset_counter, shift_right, count_up, count_down, load_counter, count,
             enable_output
   );

   // Datapath side: drives status, obeys controls.
   modport slave (
      output cout, down_counter_zero, last_queen_counter_zero, last_cell, safe,
      input  reset_counter, shift_right, count_up, count_down, load_counter, count,
             enable_output
   );
endinterface

// File: rtl/queen_controller.sv
// Sequencing FSM for the 8-queen backtracking datapath.
// Places queens row by row, backtracks on exhausted rows and streams each
// solution out one row per cycle (rows 7 down to 0).
// Build option: define ALL_SOLUTIONS_EN to keep searching after each solution
// until the search space is exhausted; otherwise stop after the first one.
// Control outputs are Mealy (state + datapath status); busy/done/no_solution/
// solution_count are registered.
module queen_controller (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   queen_controller_if.master dp,
   output logic               busy,
   output logic               done,
   output logic               no_solution,
   output logic [6:0]         solution_count
);

   localparam int unsigned COUNT_W = 7;
   localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(127);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_CHECK,
      S_BACK,
      S_LOAD,
      S_EMIT,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic reset_counter;
   logic shift_right;
   logic count_up;
   logic count_down;
   logic load_counter;
   logic count;
   logic enable_output;

   logic retreat;     // current queen must move: shift, backtrack or give up
   logic clr_stats;   // new search accepted
   logic found;       // solution found, bump the counter
   logic exhausted;   // search space exhausted
   logic finished;    // first solution fully emitted, stop

   // Next-state and Mealy control decode.
   always_comb begin
      state_nxt     = state;
      reset_counter = 1'b0;
      shift_right   = 1'b0;
      count_up      = 1'b0;
      count_down    = 1'b0;
      load_counter  = 1'b0;
      count         = 1'b0;
      enable_output = 1'b0;
      retreat       = 1'b0;
      clr_stats     = 1'b0;
      found         = 1'b0;
      exhausted     = 1'b0;
      finished      = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_INIT;
               clr_stats = 1'b1;
            end
         end
         S_INIT: begin
            reset_counter = 1'b1;
            state_nxt     = S_CHECK;
         end
         S_CHECK: begin
            if (dp.safe && dp.cout) begin
               state_nxt = S_LOAD;
            end else if (dp.safe) begin
               count_up = 1'b1;
            end else begin
               retreat = 1'b1;
            end
         end
         // The row we backed into was safe, so it can only move on.
         S_BACK: begin
            retreat = 1'b1;
         end
         S_LOAD: begin
            load_counter = 1'b1;
            found        = 1'b1;
            state_nxt    = S_EMIT;
         end
         S_EMIT: begin
            enable_output = 1'b1;
            count         = 1'b1;
            if (dp.down_counter_zero) begin
`ifdef ALL_SOLUTIONS_EN
               // Row 7 is treated as unsafe so the search carries on.
               retreat = 1'b1;
`else
               finished  = 1'b1;
               state_nxt = S_DONE;
`endif
            end
         end
         S_DONE: begin
            if (!start) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Shared move-on rule: next column, else give up at row 0, else back up.
      if (retreat) begin
         if (!dp.last_cell) begin
            shift_right = 1'b1;
            state_nxt   = S_CHECK;
         end else if (dp.last_queen_counter_zero) begin
            exhausted = 1'b1;
            state_nxt = S_DONE;
         end else begin
            count_down = 1'b1;
            state_nxt  = S_BACK;
         end
      end
   end

   assign dp.reset_counter = reset_counter;
   assign dp.shift_right   = shift_right;
   assign dp.count_up      = count_up;
   assign dp.count_down    = count_down;
   assign dp.load_counter  = load_counter;
   assign dp.count         = count;
   assign dp.enable_output = enable_output;

   // State register and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         no_solution    <= 1'b0;
         solution_count <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
         done  <= (state_nxt == S_DONE);

         if (clr_stats) begin
            no_solution    <= 1'b0;
            solution_count <= '0;
         end else if (found && (solution_count != COUNT_MAX)) begin
            solution_count <= solution_count + COUNT_W'(1);
         end

         if (exhausted) begin
`ifdef ALL_SOLUTIONS_EN
            no_solution <= (solution_count == '0);
`else
            no_solution <= 1'b1;
`endif
         end else if (finished) begin
            no_solution <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_queen_controller.sv
// Self-checking bench for queen_controller: behavioural datapath, a software
// 8-queen solver as reference, plus forced-status corner cases.
module tb_queen_controller;

   localparam int RUN_BUDGET = 40000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, no_solution;
   logic [6:0] solution_count;

   queen_controller_if bus ();

   queen_controller dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .dp             (bus),
      .busy           (busy),
      .done           (done),
      .no_solution    (no_solution),
      .solution_count (solution_count)
   );

   always #5 clk = ~clk;

   // behavioural datapath
   logic [2:0] col [8];
   logic [2:0] row = 3'd0;
   logic [2:0] dcnt = 3'd0;
   logic       m_safe;
   logic [7:0] out_bus;
   int         dr, dc;

   initial for (int i = 0; i < 8; i++) col[i] = 3'd0;

   always @(posedge clk) begin
      if (bus.reset_counter) begin
         row <= 3'd0;
         for (int i = 0; i < 8; i++) col[i] <= 3'd0;
      end else if (bus.shift_right) begin
         col[row] <= col[row] + 3'd1;
      end else if (bus.count_up) begin
         row <= row + 3'd1;
      end else if (bus.count_down) begin
         col[row] <= 3'd0;
         row <= row - 3'd1;
      end
      if (bus.load_counter) dcnt <= 3'd7;
      else if (bus.count) dcnt <= dcnt - 3'd1;
   end

   always_comb begin
      m_safe = 1'b1;
      dr = 0;
      dc = 0;
      for (int j = 0; j < 8; j++) begin
         if (j < int'(row)) begin
            dr = int'(row) - j;
            dc = int'(col[row]) - int'(col[j]);
            if (dc == 0 || dc == dr || dc == -dr) m_safe = 1'b0;
         end
      end
   end

   assign out_bus = bus.enable_output ? (8'd1 << col[dcnt]) : 8'd0;

   // status mux: datapath model or forced values
   logic force_mode = 1'b0;
   logic f_safe = 1'b0, f_last = 1'b0, f_lqcz = 1'b0, f_cout = 1'b0, f_dcz = 1'b0;

   assign bus.safe                    = force_mode ? f_safe : m_safe;
   assign bus.last_cell               = force_mode ? f_last : (col[row] == 3'd7);
   assign bus.last_queen_counter_zero = force_mode ? f_lqcz : (row == 3'd0);
   assign bus.cout                    = force_mode ? f_cout : (row == 3'd7);
   assign bus.down_counter_zero       = force_mode ? f_dcz : (dcnt == 3'd0);

   logic [6:0] ctl;
   assign ctl = {bus.reset_counter, bus.shift_right, bus.count_up, bus.count_down,
                 bus.load_counter, bus.count, bus.enable_output};

   localparam logic [6:0] CTL_SR = 7'b0100000;
   localparam logic [6:0] CTL_CU = 7'b0010000;
   localparam logic [6:0] CTL_CD = 7'b0001000;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference: every solution in search order, row r column in bits [3r+:3]
   logic [23:0] ref_q [$];

   function automatic void solve_all();
      int c [8];
      int r;
      bit ok;
      logic [23:0] p;
      r = 0;
      c[0] = 0;
      while (r >= 0) begin
         if (c[r] > 7) begin
            r--;
            if (r >= 0) c[r]++;
         end else begin
            ok = 1'b1;
            for (int j = 0; j < r; j++)
               if (c[j] == c[r] || c[j] - c[r] == r - j || c[r] - c[j] == r - j) ok = 1'b0;
            if (!ok) begin
               c[r]++;
            end else if (r == 7) begin
               p = '0;
               for (int k = 0; k < 8; k++) p[3*k +: 3] = 3'(c[k]);
               ref_q.push_back(p);
               c[r]++;
            end else begin
               r++;
               c[r] = 0;
            end
         end
      end
   endfunction

   logic [7:0] obs_q [$];
   int         runs_q [$];
   int         excl_viol;

   task automatic run_search(input bit hold);
      int cyc, run, rc_extra, last_en, done_at, nbad, nmis, exp_n, exp_cnt;
      logic [7:0] first_exp [8];
      logic [7:0] want;
      first_exp = '{8'h08, 8'h02, 8'h40, 8'h04, 8'h20, 8'h80, 8'h10, 8'h01};
`ifdef ALL_SOLUTIONS_EN
      exp_n = ref_q.size();
`else
      exp_n = 1;
`endif
      exp_cnt = (exp_n > 127) ? 127 : exp_n;
      obs_q.delete();
      runs_q.delete();
      excl_viol = 0;
      @(negedge clk);
      start = 1'b1;
      #1 check("idle_quiet", ctl, 7'd0);
      @(negedge clk);
      check("start_rc", bus.reset_counter, 1);
      check("start_busy", busy, 1);
      if (!hold) start = 1'b0;
      cyc = 0; run = 0; rc_extra = 0; last_en = -1; done_at = -1;
      while (done_at < 0 && cyc < RUN_BUDGET) begin
         @(negedge clk);
         cyc++;
         if ($countones({bus.reset_counter, bus.shift_right, bus.count_up, bus.count_down}) > 1)
            excl_viol++;
         if (bus.reset_counter) rc_extra++;
         if (bus.enable_output) begin
            obs_q.push_back(out_bus);
            run++;
            last_en = cyc;
         end else if (run != 0) begin
            runs_q.push_back(run);
            run = 0;
         end
         if (done) done_at = cyc;
      end
      if (run != 0) runs_q.push_back(run);
      check("run_timeout", done_at >= 0, 1);
      check("bursts", runs_q.size(), exp_n);
      nbad = 0;
      foreach (runs_q[i]) if (runs_q[i] != 8) nbad++;
      check("burst_len", nbad, 0);
      check("obs_len", obs_q.size(), 8 * exp_n);
      for (int k = 0; k < 8; k++)
         check($sformatf("first_row%0d", 7 - k), (k < obs_q.size()) ? obs_q[k] : 8'h00,
               first_exp[k]);
      nmis = 0;
      for (int s = 0; s < exp_n; s++)
         for (int k = 0; k < 8; k++) begin
            want = 8'd1 << ref_q[s][3*(7-k) +: 3];
            if (8*s + k >= obs_q.size()) nmis++;
            else if (obs_q[8*s + k] !== want) nmis++;
         end
      check("all_rows", nmis, 0);
      check("done", done, 1);
      check("done_busy", busy, 0);
      check("no_sol", no_solution, 0);
      check("sol_count", solution_count, exp_cnt);
      check("excl", excl_viol, 0);
      check("rc_once", rc_extra, 0);
`ifndef ALL_SOLUTIONS_EN
      check("done_lat", done_at - last_en, 1);
`endif
      if (hold) begin
         repeat ($urandom_range(2, 5)) begin
            @(negedge clk);
            check("hold_done", done, 1);
         end
         start = 1'b0;
      end
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(3, 40)) @(negedge clk);
      check("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctl", ctl, 7'd0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // start from IDLE with forced status and land in CHECK
   task automatic forced_enter();
      @(negedge clk);
      force_mode = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check("f_rc", bus.reset_counter, 1);
      check("f_cleared", solution_count, 0);
      start = 1'b0;
      @(negedge clk);
   endtask

   // in CHECK: row 0 exhausted ends the search with no_solution
   task automatic forced_exhaust(input string tag);
      f_safe = 1'b0; f_last = 1'b1; f_lqcz = 1'b1; f_cout = 1'b0;
      #1 check({tag, "_quiet"}, ctl, 7'd0);
      @(negedge clk);
      check({tag, "_done"}, done, 1);
      check({tag, "_nosol"}, no_solution, 1);
      check({tag, "_busy"}, busy, 0);
      @(negedge clk);
      check({tag, "_idle"}, done, 0);
   endtask

   task automatic forced_walk();
      int k, m;
      forced_enter();
      k = $urandom_range(1, 6);
      m = $urandom_range(0, 3);
      f_safe = 1'b1; f_cout = 1'b0; f_last = 1'b0; f_lqcz = 1'b0;
      repeat (k) begin
         #1 check("w_up", ctl, CTL_CU);
         @(negedge clk);
      end
      f_safe = 1'b0; f_last = 1'b1; f_lqcz = 1'b0;
      #1 check("w_down", ctl, CTL_CD);
      @(negedge clk);
      f_safe = 1'b1;
      repeat (m) begin
         #1 check("w_back_down", ctl, CTL_CD);
         @(negedge clk);
      end
      f_last = 1'b0;
      #1 check("w_back_shift", ctl, CTL_SR);
      @(negedge clk);
      f_safe = 1'b1; f_last = 1'b1;
      #1 check("w_recheck", ctl, CTL_CU);
      @(negedge clk);
      forced_exhaust("w_end");
   endtask

   initial begin
      solve_all();
      repeat (3) @(negedge clk);
      check("rst_ctl", ctl, 7'd0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_nosol", no_solution, 0);
      check("rst_count", solution_count, 0);
      rst_n = 1'b1;
      repeat ($urandom_range(0, 4)) @(negedge clk);

      run_search(1'b0);
      mid_reset();
      run_search(1'b1);

      forced_enter();
      forced_exhaust("f_x");
      forced_walk();
      force_mode = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
